// File: rtl/ppu_pkg.sv
// Shared PPU definitions: OAM DMA state encoding, register map constants
// and the OAM address helper used by the DMA write path.
package ppu_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } dma_state_t;

    localparam int          OAM_SIZE    = 256;
    localparam logic [15:0] REG_OAMADDR = 16'h2003;
    localparam logic [15:0] REG_OAMDATA = 16'h2004;
    localparam logic [15:0] REG_OAMDMA  = 16'h4014;

    // DMA bytes land relative to OAMADDR and wrap inside the 256-byte OAM.
    function automatic logic [7:0] oam_index(input logic [7:0] base,
                                             input logic [7:0] offset);
        return base + offset;
    endfunction

endpackage

// File: rtl/oam_dma_ctrl.sv
// OAM write sequencer: CPU $2003/$2004 writes and $4014 page DMA into
// primary OAM. Sprite evaluation owns OAM while render_active is high, so
// every write is suppressed then (DMA still steps through its bytes).
// Optional: define OAM_RENDER_GLITCH_EN to make a $2004 write during
// rendering bump OAMADDR by 4 instead of being ignored.
module oam_dma_ctrl
    import ppu_pkg::*;
#(
    parameter int DMA_LEN   = 256,
    parameter int ODD_ALIGN = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_ce,
    input  logic [7:0]  cpu_wdata,
    input  logic        wr_2003,
    input  logic        wr_2004,
    input  logic        wr_4014,
    input  logic        render_active,
    input  logic [7:0]  dma_data_in,
    output logic        cpu_rdy,
    output logic [15:0] dma_addr,
    output logic        dma_rd,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_data,
    output logic        oam_we,
    output logic [7:0]  oamaddr_q,
    output logic        dma_busy,
    output logic        dma_done
);

    localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

    dma_state_t state, state_nxt;
    logic       parity;     // CPU cycle parity, flips on every cpu_ce
    logic       odd_start;  // parity of the cycle that issued $4014
    logic [7:0] page_q;
    logic [7:0] cnt_q;
    logic [7:0] byte_q;
    logic       rd_pend;    // bus data arrives the clk after dma_rd
    logic       dma_start;
    logic       cpu_reg_wr; // $2004 accepted this cycle (idle, not DMA start)

    assign dma_addr   = {page_q, cnt_q};
    assign cpu_reg_wr = (state == IDLE) && cpu_ce && wr_2004 && !wr_4014;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state and strobe outputs; strobes are qualified by cpu_ce so each
    // lasts exactly one clk even though a CPU cycle spans several clks.
    always_comb begin
        state_nxt = state;
        dma_start = 1'b0;
        dma_rd    = 1'b0;
        oam_we    = 1'b0;
        oam_addr  = 8'h00;
        oam_data  = 8'h00;
        cpu_rdy   = 1'b0;
        dma_busy  = 1'b1;
        dma_done  = 1'b0;
        case (state)
            IDLE: begin
                cpu_rdy  = 1'b1;
                dma_busy = 1'b0;
                if (cpu_ce && wr_4014) begin
                    dma_start = 1'b1;
                    state_nxt = HALT;
                end else if (cpu_reg_wr && !render_active) begin
                    oam_we   = 1'b1;
                    oam_addr = oamaddr_q;
                    oam_data = cpu_wdata;
                end
            end
            HALT: begin
                if (cpu_ce)
                    state_nxt = ((ODD_ALIGN != 0) && odd_start) ? ALIGN : READ;
            end
            ALIGN: begin
                if (cpu_ce) state_nxt = READ;
            end
            READ: begin
                if (cpu_ce) begin
                    dma_rd    = 1'b1;
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                if (cpu_ce) begin
                    oam_we    = !render_active;
                    oam_addr  = oam_index(oamaddr_q, cnt_q);
                    oam_data  = byte_q;
                    state_nxt = (cnt_q == LAST_IDX) ? DONE : READ;
                end
            end
            DONE: begin
                cpu_rdy   = 1'b1;
                dma_busy  = 1'b0;
                dma_done  = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                cpu_rdy   = 1'b1;
                dma_busy  = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: parity, DMA page/counter, fetched byte and OAMADDR
    always_ff @(posedge clk) begin
        if (reset) begin
            parity    <= 1'b0;
            odd_start <= 1'b0;
            page_q    <= 8'h00;
            cnt_q     <= 8'h00;
            byte_q    <= 8'h00;
            rd_pend   <= 1'b0;
            oamaddr_q <= 8'h00;
        end else begin
            rd_pend <= dma_rd;
            if (rd_pend) byte_q <= dma_data_in;
            if (cpu_ce)  parity <= ~parity;
            if (dma_start) begin
                page_q    <= cpu_wdata;
                cnt_q     <= 8'h00;
                odd_start <= parity;
            end else if (state == WRITE && cpu_ce) begin
                cnt_q <= cnt_q + 8'd1;
            end
            if (state == IDLE && cpu_ce && wr_2003) begin
                oamaddr_q <= cpu_wdata;
            end else if (cpu_reg_wr) begin
                if (!render_active) begin
                    oamaddr_q <= oamaddr_q + 8'd1;
                end else begin
`ifdef OAM_RENDER_GLITCH_EN
                    oamaddr_q <= oamaddr_q + 8'd4;
`else
                    oamaddr_q <= oamaddr_q;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl. Expected OAM writes are queued when
// stimulus is issued and popped as the DUT produces oam_we.
module tb_oam_dma_ctrl;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_ce = 1'b0;
    logic [7:0]  cpu_wdata = 8'h00;
    logic        wr_2003 = 1'b0, wr_2004 = 1'b0, wr_4014 = 1'b0;
    logic        render_active = 1'b0;
    logic [7:0]  dma_data_in = 8'h00;
    logic        cpu_rdy, dma_rd, oam_we, dma_busy, dma_done;
    logic [15:0] dma_addr;
    logic [7:0]  oam_addr, oam_data, oamaddr_q;

    oam_dma_ctrl #(.DMA_LEN(256), .ODD_ALIGN(1)) dut (
        .clk(clk), .reset(reset), .cpu_ce(cpu_ce), .cpu_wdata(cpu_wdata),
        .wr_2003(wr_2003), .wr_2004(wr_2004), .wr_4014(wr_4014),
        .render_active(render_active), .dma_data_in(dma_data_in),
        .cpu_rdy(cpu_rdy), .dma_addr(dma_addr), .dma_rd(dma_rd),
        .oam_addr(oam_addr), .oam_data(oam_data), .oam_we(oam_we),
        .oamaddr_q(oamaddr_q), .dma_busy(dma_busy), .dma_done(dma_done)
    );

    always #5 clk = ~clk;

    int          checks = 0, failures = 0;
    wr_t         sb[$];
    logic        par = 1'b0;         // model of CPU cycle parity
    logic [7:0]  oa = 8'h00;         // model of OAMADDR
    logic [7:0]  exp_page = 8'h00;
    logic [7:0]  rd_idx = 8'h00;
    logic        rd_pend = 1'b0;
    logic [15:0] rd_addr = 16'h0000;
    int          rdy_low = 0, done_cnt = 0, wr_seen = 0;

    function automatic logic [7:0] mem_rd(input logic [15:0] a);
        logic [7:0] hi, lo;
        hi = a[15:8] - 8'd2;
        lo = a[7:0];
        return lo + hi * 8'h3B;   // page 2 holds byte i at offset i
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Observe DUT outputs a little after the input change, away from posedge
    task automatic sample();
        wr_t e;
        if (oam_we) begin
            wr_seen++;
            if (sb.size() == 0) begin
                chk("oam_we_unexpected", 32'(oam_we), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("oam_write", {oam_addr, oam_data}, {e.addr, e.data});
            end
        end
        if (dma_rd) begin
            chk("dma_addr", dma_addr, {exp_page, rd_idx});
            rd_idx++;
            rd_pend = 1'b1;
            rd_addr = dma_addr;
        end
        if (dma_done) done_cnt++;
        if (cpu_ce && !cpu_rdy) rdy_low++;
    endtask

    // One CPU cycle = 2 clks: cpu_ce high for the first, low for the second
    task automatic cpu_cycle(input logic w3, input logic w4, input logic w14, input logic [7:0] d);
        @(negedge clk);
        cpu_ce = 1'b1; wr_2003 = w3; wr_2004 = w4; wr_4014 = w14; cpu_wdata = d;
        #2 sample();
        @(negedge clk);
        cpu_ce = 1'b0; wr_2003 = 1'b0; wr_2004 = 1'b0; wr_4014 = 1'b0;
        if (rd_pend) begin
            dma_data_in = mem_rd(rd_addr);
            rd_pend = 1'b0;
        end
        #2 sample();
        par = ~par;
    endtask

    task automatic push_dma(input logic [7:0] page);
        for (int i = 0; i < 256; i++)
            sb.push_back('{addr: oa + 8'(i), data: mem_rd({page, 8'(i)})});
        exp_page = page;
        rd_idx   = 8'h00;
        rdy_low  = 0;
        done_cnt = 0;
    endtask

    task automatic run_dma(input string tag, input logic [7:0] page, input logic odd,
                           input logic with_2004, input logic inject);
        int n;
        if (par != odd) cpu_cycle(1'b0, 1'b0, 1'b0, 8'h00);
        push_dma(page);
        cpu_cycle(1'b0, with_2004, 1'b1, page);
        n = 0;
        while (dma_busy && n < 700) begin
            cpu_cycle(inject && n == 50, inject && n == 50, inject && n == 60, 8'h77);
            n++;
        end
        chk({tag, "_finished"}, 32'(n < 700), 32'd1);
        chk({tag, "_halt_cycles"}, rdy_low, odd ? 514 : 513);
        chk({tag, "_done_pulses"}, done_cnt, 1);
        chk({tag, "_sb_left"}, sb.size(), 0);
        chk({tag, "_oamaddr"}, oamaddr_q, oa);
        chk({tag, "_rdy"}, cpu_rdy, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; cpu_ce = 1'b0;
        @(negedge clk);
        #2;
        par = 1'b0; oa = 8'h00; rd_pend = 1'b0;
    endtask

    initial begin
        int n;
        logic [7:0] glitch_exp;

        // Reset state
        do_reset();
        chk("rst_cpu_rdy", cpu_rdy, 1'b1);
        chk("rst_busy", dma_busy, 1'b0);
        chk("rst_done", dma_done, 1'b0);
        chk("rst_oam_we", oam_we, 1'b0);
        chk("rst_dma_rd", dma_rd, 1'b0);
        chk("rst_oamaddr", oamaddr_q, 8'h00);
        chk("rst_dma_addr", dma_addr, 16'h0000);
        @(negedge clk);
        reset = 1'b0;

        // $2003 then two $2004 writes
        cpu_cycle(1'b1, 1'b0, 1'b0, 8'h10); oa = 8'h10;
        sb.push_back('{addr: 8'h10, data: 8'hAB});
        sb.push_back('{addr: 8'h11, data: 8'hCD});
        cpu_cycle(1'b0, 1'b1, 1'b0, 8'hAB);
        cpu_cycle(1'b0, 1'b1, 1'b0, 8'hCD); oa = 8'h12;
        chk("reg_oamaddr", oamaddr_q, 8'h12);
        chk("reg_sb_left", sb.size(), 0);

        // OAMADDR wraps FF -> 00 after a $2004 write
        cpu_cycle(1'b1, 1'b0, 1'b0, 8'hFF); oa = 8'hFF;
        sb.push_back('{addr: 8'hFF, data: 8'h11});
        cpu_cycle(1'b0, 1'b1, 1'b0, 8'h11); oa = 8'h00;
        chk("wrap_oamaddr", oamaddr_q, 8'h00);
        chk("wrap_sb_left", sb.size(), 0);

        // DMA on even cycle, then odd cycle with a simultaneous $2004
        run_dma("dma_even", 8'h02, 1'b0, 1'b0, 1'b0);
        run_dma("dma_odd", 8'h02, 1'b1, 1'b1, 1'b0);

        // OAMADDR offset with wrap, spurious strobes mid-DMA are ignored
        cpu_cycle(1'b1, 1'b0, 1'b0, 8'hF0); oa = 8'hF0;
        run_dma("dma_off", 8'h03, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of a DMA
        cpu_cycle(1'b1, 1'b0, 1'b0, 8'h00); oa = 8'h00;
        if (par) cpu_cycle(1'b0, 1'b0, 1'b0, 8'h00);
        push_dma(8'h02);
        wr_seen = 0;
        cpu_cycle(1'b0, 1'b0, 1'b1, 8'h02);
        n = 0;
        while (wr_seen < 100 && n < 400) begin
            cpu_cycle(1'b0, 1'b0, 1'b0, 8'h00);
            n++;
        end
        chk("abort_reached", wr_seen, 100);
        do_reset();
        chk("abort_rdy", cpu_rdy, 1'b1);
        chk("abort_busy", dma_busy, 1'b0);
        chk("abort_we", oam_we, 1'b0);
        chk("abort_sb_left", sb.size(), 156);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) cpu_cycle(1'b0, 1'b0, 1'b0, 8'h00);
        chk("abort_no_more_writes", wr_seen, 100);
        chk("abort_idle_busy", dma_busy, 1'b0);

        // $2004 while rendering: no write
        cpu_cycle(1'b1, 1'b0, 1'b0, 8'h20); oa = 8'h20;
        render_active = 1'b1;
        cpu_cycle(1'b0, 1'b1, 1'b0, 8'h55);
        render_active = 1'b0;
`ifdef OAM_RENDER_GLITCH_EN
        glitch_exp = 8'h24;
`else
        glitch_exp = 8'h20;
`endif
        chk("render_oamaddr", oamaddr_q, glitch_exp);
        chk("render_no_write", wr_seen, 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/oam_dma_ctrl.md
Name: oam_dma_ctrl

Overview:
Sequences and arbitrates all writes into the PPU primary OAM.
- CPU $2003 (OAMADDR) and $2004 (OAMDATA) register writes.
- $4014 OAM DMA: 256 bytes copied from CPU page XX00-XXFF into OAM while the CPU is halted.
- The sprite evaluation block owns the OAM port whenever render_active is high; this block then drops writes.
Sits between the CPU bus decode and ppu_spr's primary OAM write port.

Parameters:
- DMA_LEN, 256, bytes per DMA transfer (power of two, ≤256).
- ODD_ALIGN, 1, 1 = insert an alignment cycle when DMA starts on an odd CPU cycle.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- cpu_ce  in  1  CPU-cycle enable; asserted at most every other clk
- cpu_wdata  in  8  CPU write data
- wr_2003  in  1  OAMADDR write strobe (qualified by cpu_ce)
- wr_2004  in  1  OAMDATA write strobe (qualified by cpu_ce)
- wr_4014  in  1  DMA start strobe (qualified by cpu_ce); cpu_wdata = page
- render_active  in  1  sprite evaluation owns OAM
- dma_data_in  in  8  CPU-bus read data, valid 1 clk after dma_rd
- cpu_rdy  out  1  low = CPU halted
- dma_addr  out  16  {page, byte counter}
- dma_rd  out  1  DMA bus read strobe, 1 clk
- oam_addr  out  8  OAM write address
- oam_data  out  8  OAM write data
- oam_we  out  1  OAM write enable, 1 clk
- oamaddr_q  out  8  current OAMADDR register
- dma_busy  out  1  DMA in progress
- dma_done  out  1  1-clk pulse on DMA completion

Behaviour:
- Reset values: cpu_rdy=1; all other outputs 0; state IDLE; parity=0; page=0; counter=0.
- Reset mid-DMA aborts immediately: IDLE, cpu_rdy=1, no further oam_we.
- Parity:
  - Toggles on every cpu_ce.
  - Even means parity=0 before the toggle.
- States and transitions (each advances only on cpu_ce unless noted):
  - IDLE: on wr_4014, latch page=cpu_wdata, counter=0, cpu_rdy=0, dma_busy=1 → HALT.
  - HALT: 1 dummy cycle. If ODD_ALIGN and the current cycle is odd → ALIGN; else → READ.
  - ALIGN: 1 dummy cycle → READ.
  - READ: dma_rd=1 for 1 clk with dma_addr={page,counter}. dma_data_in latched into the byte register on the next clk → WRITE.
  - WRITE:
    - oam_addr=oamaddr_q+counter (mod 256), oam_data=byte register, oam_we=1 for 1 clk.
    - counter += 1.
    - If counter was DMA_LEN-1 → DONE; else → READ.
  - DONE (advances on next clk, not cpu_ce): dma_done=1, cpu_rdy=1, dma_busy=0 → IDLE.
- Total halt length: 513 CPU cycles (even start) or 514 (odd start) for DMA_LEN=256.
- OAMADDR:
  - wr_2003 sets oamaddr_q=cpu_wdata.
  - wr_2004 in IDLE with render_active=0: oam_we=1 at oamaddr_q with cpu_wdata, then oamaddr_q += 1 (wraps FF→00).
  - DMA leaves oamaddr_q unchanged (full 256-byte wrap).
- render_active=1:
  - oam_we is forced 0.
  - DMA WRITE steps still consume their cycle and advance counter (byte lost).
  - wr_2004 is dropped and oamaddr_q is unchanged.
- Simultaneous events and mid-DMA strobes:
  - wr_4014 while busy: ignored.
  - wr_2003/wr_2004 while busy: ignored (CPU is halted; strobe is spurious).
  - wr_4014 and wr_2004 in the same cycle: DMA wins; the $2004 write is dropped.
- Widths: counter is 8 bits, wrap-around intended; oam_addr addition is mod 256.

Optional Feature:
- Macro OAM_RENDER_GLITCH_EN.
- Defined: wr_2004 during render_active=1 performs no write but increments oamaddr_q by 4 (mod 256), matching 2C02 behaviour.
- Undefined: such writes are fully ignored and oamaddr_q holds.

Decomposition:
- ppu_pkg holds:
  - the state enum (IDLE, HALT, ALIGN, READ, WRITE, DONE);
  - constants OAM_SIZE=256, REG_OAMADDR=16'h2003, REG_OAMDATA=16'h2004, REG_OAMDMA=16'h4014.
- No sub-module is needed: parity toggle, counter and FSM are inline in one module.

Test Plan:
- wr_2003 0x10, then wr_2004 0xAB, 0xCD (render_active=0) → oam_we at 0x10=AB, 0x11=CD; oamaddr_q=0x12.
- wr_4014 page 0x02 on an even cycle, memory byte i = i → cpu_rdy low exactly 513 cpu_ce cycles; OAM[i]=i; dma_addr sweeps 0x0200-0x02FF; one dma_done pulse.
- Same DMA started on an odd cycle → cpu_rdy low 514 cycles.
- oamaddr_q=0xF0, DMA page 0x03 → byte 0x0300 lands at OAM 0xF0, byte 0x0310 at OAM 0x00; oamaddr_q stays 0xF0 afterwards.
- reset asserted at DMA byte 100 → next clk cpu_rdy=1, oam_we=0, dma_busy=0; OAM[100+] untouched.
- render_active=1, wr_2004 0x55 with oamaddr_q=0x20 → no oam_we; oamaddr_q=0x24 with OAM_RENDER_GLITCH_EN, 0x20 without.
